watch_ctrl: RTL and testbench



---
 rtl/watch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_watch_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/watch_ctrl.sv
// Mode and sequencing controller for the watch time-keeping chain: 1 s prescaler,
// button debounce, RUN/SET_HOUR/SET_MIN sequencing, counter strobes and blink enables.
module watch_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DEB_CYC   = 500000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_n,
  input  logic       btn_up_n,
  input  logic [3:0] sec_10,
  input  logic [3:0] sec1,
  input  logic [3:0] min_10,
  input  logic [3:0] min1,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       sec_clr,
  output logic [1:0] set_mode,
  output logic       hour_vis,
  output logic       min_vis
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  // Bit 0 is the mode button, bit 1 the up button; all levels active-low.
  logic [1:0]    btn_raw, sync_a, sync_b, accepted, press;
  logic [DW-1:0] deb_cnt [2];
  logic          mode_evt, up_evt;

  assign btn_raw  = {btn_up_n, btn_mode_n};
  assign mode_evt = press[0];
  assign up_evt   = press[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a   <= '1;
      sync_b   <= '1;
      accepted <= '1;
      press    <= '0;
      // NOTE: the small per-button counter array is reset explicitly; it is control state, not storage.
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] != accepted[i]) begin
          if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
            accepted[i] <= sync_b[i];
            deb_cnt[i]  <= '0;
            press[i]    <= ~sync_b[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  mode_e         state, state_nx;
  logic [TW-1:0] presc;
  logic          tick;
  logic [BW-1:0] blink_cnt, blink_cnt_nx;
  logic          phase, phase_nx;
  logic          sec_inc_nx, min_inc_nx, hour_inc_nx, sec_clr_nx;
  logic          hour_vis_nx, min_vis_nx;
  logic          sec_59, min_59;

  assign tick   = (state == RUN) && (presc == TW'(TICK_DIV - 1));
  assign sec_59 = (sec_10 == 4'd5) && (sec1 == 4'd9);
  assign min_59 = (min_10 == 4'd5) && (min1 == 4'd9);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    sec_inc_nx  = 1'b0;
    min_inc_nx  = 1'b0;
    hour_inc_nx = 1'b0;
    sec_clr_nx  = 1'b0;
    case (state)
      RUN: begin
        if (mode_evt) state_nx = SET_HOUR;
        if (tick) begin
          sec_inc_nx  = 1'b1;
          min_inc_nx  = sec_59;
          hour_inc_nx = sec_59 && min_59;
        end
      end
      SET_HOUR: begin
        if (mode_evt)    state_nx    = SET_MIN;
        else if (up_evt) hour_inc_nx = 1'b1;
      end
      SET_MIN: begin
        if (mode_evt) begin
          state_nx   = RUN;
          sec_clr_nx = 1'b1;
        end else if (up_evt) begin
          min_inc_nx = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // Blink phase restarts visible on each entry into a set state.
  always_comb begin
    blink_cnt_nx = '0;
    phase_nx     = 1'b1;
    if (state_nx != RUN && state_nx == state) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        phase_nx = ~phase;
      end else begin
        blink_cnt_nx = blink_cnt + BW'(1);
        phase_nx     = phase;
      end
    end
    hour_vis_nx = (state_nx == SET_HOUR) ? phase_nx : 1'b1;
    min_vis_nx  = (state_nx == SET_MIN)  ? phase_nx : 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      presc     <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      sec_inc   <= 1'b0;
      min_inc   <= 1'b0;
      hour_inc  <= 1'b0;
      sec_clr   <= 1'b0;
      hour_vis  <= 1'b1;
      min_vis   <= 1'b1;
    end else begin
      state     <= state_nx;
      if (state != RUN || tick) presc <= '0;
      else                      presc <= presc + TW'(1);
      blink_cnt <= blink_cnt_nx;
      phase     <= phase_nx;
      sec_inc   <= sec_inc_nx;
      min_inc   <= min_inc_nx;
      hour_inc  <= hour_inc_nx;
      sec_clr   <= sec_clr_nx;
      hour_vis  <= hour_vis_nx;
      min_vis   <= min_vis_nx;
    end
  end

  assign set_mode = state;

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed self-checking bench for watch_ctrl with short divider/debounce/blink
// settings so every timing relation can be checked cycle-exactly.
module tb_watch_ctrl;

  localparam int TD = 4;
  localparam int DC = 3;
  localparam int BD = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode_n = 1'b1;
  logic       btn_up_n = 1'b1;
  logic [3:0] sec_10 = 4'd0, sec1 = 4'd0, min_10 = 4'd0, min1 = 4'd0;
  logic       sec_inc, min_inc, hour_inc, sec_clr, hour_vis, min_vis;
  logic [1:0] set_mode;

  int tests = 0;
  int fails = 0;
  int n_sec, n_min, n_hour, n_clr;
  int found, clr_k, inc_k;

  watch_ctrl #(.TICK_DIV(TD), .DEB_CYC(DC), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst),
    .btn_mode_n(btn_mode_n), .btn_up_n(btn_up_n),
    .sec_10(sec_10), .sec1(sec1), .min_10(min_10), .min1(min1),
    .sec_inc(sec_inc), .min_inc(min_inc), .hour_inc(hour_inc), .sec_clr(sec_clr),
    .set_mode(set_mode), .hour_vis(hour_vis), .min_vis(min_vis)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (sec_inc === 1'b1)  n_sec++;
    if (min_inc === 1'b1)  n_min++;
    if (hour_inc === 1'b1) n_hour++;
    if (sec_clr === 1'b1)  n_clr++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic clear_counts();
    n_sec = 0; n_min = 0; n_hour = 0; n_clr = 0;
  endtask

  task automatic press(input bit up, input int hold, input int gap);
    if (up) btn_up_n = 1'b0;
    else    btn_mode_n = 1'b0;
    run(hold);
    btn_up_n   = 1'b1;
    btn_mode_n = 1'b1;
    run(gap);
  endtask

  initial begin
    clear_counts();

    // Reset state
    run(2);
    check("rst_set_mode", 32'(set_mode), 0);
    check("rst_strobes", 32'({sec_inc, min_inc, hour_inc, sec_clr}), 0);
    check("rst_hour_vis", 32'(hour_vis), 1);
    check("rst_min_vis", 32'(min_vis), 1);

    // 1: sec_inc every TD cycles, first one TD cycles after release
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("t1_sec_inc_%0d", k), 32'(sec_inc), 32'(k % TD == 0));
      check($sformatf("t1_carry_%0d", k), 32'({min_inc, hour_inc}), 0);
    end

    // 2: full carry at 59:59, minute-only carry at 12:59
    sec_10 = 4'd5; sec1 = 4'd9; min_10 = 4'd5; min1 = 4'd9;
    for (int k = 13; k <= 16; k++) begin
      cyc();
      check($sformatf("t2_full_%0d", k), 32'({sec_inc, min_inc, hour_inc}), (k == 16) ? 32'b111 : 32'b000);
    end
    min_10 = 4'd1; min1 = 4'd2;
    for (int k = 17; k <= 20; k++) begin
      cyc();
      check($sformatf("t2_min_%0d", k), 32'({sec_inc, min_inc, hour_inc}), (k == 20) ? 32'b110 : 32'b000);
    end
    sec_10 = 4'd0; sec1 = 4'd0; min_10 = 4'd0; min1 = 4'd0;

    // 3: glitch rejected, full press enters SET_HOUR after 2+3+1 edges, hour blink
    btn_mode_n = 1'b0;
    run(2);
    btn_mode_n = 1'b1;
    run(8);
    check("t3_glitch_mode", 32'(set_mode), 0);
    btn_mode_n = 1'b0;
    found = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (set_mode == 2'd1) begin
        found = k;
        break;
      end
    end
    check("t3_press_latency", 32'(found), 6);
    for (int j = 1; j <= 10; j++) begin
      cyc();
      if (j == 4) btn_mode_n = 1'b1;
      check($sformatf("t3_hour_vis_%0d", j), 32'(hour_vis), (j >= 5 && j < 10) ? 32'd0 : 32'd1);
      check($sformatf("t3_min_vis_%0d", j), 32'(min_vis), 1);
      check($sformatf("t3_no_tick_%0d", j), 32'(sec_inc), 0);
    end
    run(10);
    check("t3_single_event", 32'(set_mode), 1);

    // 4: up presses in SET_HOUR, then SET_MIN at 59 without hour carry
    clear_counts();
    press(1'b1, 6, 8);
    press(1'b1, 6, 8);
    press(1'b1, 20, 8);
    check("t4_hour_inc_cnt", 32'(n_hour), 3);
    check("t4_sec_inc_cnt", 32'(n_sec), 0);
    check("t4_min_inc_cnt", 32'(n_min), 0);
    press(1'b0, 6, 8);
    check("t4_set_min", 32'(set_mode), 2);
    check("t4_hour_vis_solid", 32'(hour_vis), 1);
    sec_10 = 4'd5; sec1 = 4'd9; min_10 = 4'd5; min1 = 4'd9;
    clear_counts();
    press(1'b1, 6, 8);
    check("t4_min_inc_cnt59", 32'(n_min), 1);
    check("t4_hour_inc_cnt59", 32'(n_hour), 0);
    check("t4_sec_inc_cnt59", 32'(n_sec), 0);
    sec_10 = 4'd0; sec1 = 4'd0; min_10 = 4'd0; min1 = 4'd0;

    // 5: back to RUN with sec_clr, prescaler restarts from 0; up ignored in RUN
    clear_counts();
    btn_mode_n = 1'b0;
    clr_k = -1;
    inc_k = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 6) btn_mode_n = 1'b1;
      if (sec_clr === 1'b1 && clr_k < 0) clr_k = k;
      if (sec_inc === 1'b1 && inc_k < 0) inc_k = k;
    end
    check("t5_sec_clr_at", 32'(clr_k), 6);
    check("t5_sec_clr_cnt", 32'(n_clr), 1);
    check("t5_first_sec_inc", 32'(inc_k), 6 + TD);
    check("t5_run_mode", 32'(set_mode), 0);
    clear_counts();
    press(1'b1, 6, 8);
    check("t5_up_run_min", 32'(n_min), 0);
    check("t5_up_run_hour", 32'(n_hour), 0);
    check("t5_up_run_clr", 32'(n_clr), 0);
    check("t5_up_run_mode", 32'(set_mode), 0);

    // 6: reset in SET_MIN with a half-debounced mode press pending
    press(1'b0, 6, 8);
    press(1'b0, 6, 8);
    check("t6_in_set_min", 32'(set_mode), 2);
    btn_mode_n = 1'b0;
    run(3);
    rst = 1'b0;
    #1;
    check("t6_rst_mode", 32'(set_mode), 0);
    check("t6_rst_strobes", 32'({sec_inc, min_inc, hour_inc, sec_clr}), 0);
    check("t6_rst_vis", 32'({hour_vis, min_vis}), 32'b11);
    btn_mode_n = 1'b1;
    clear_counts();
    run(3);
    check("t6_in_rst_strobes", 32'(n_sec + n_min + n_hour + n_clr), 0);
    rst = 1'b1;
    run(20);
    check("t6_post_rst_mode", 32'(set_mode), 0);
    check("t6_post_rst_clr", 32'(n_clr), 0);
    check("t6_post_rst_carry", 32'(n_min + n_hour), 0);
    press(1'b0, 6, 8);
    check("t6_new_press", 32'(set_mode), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
